// File: rtl/package_dpd.sv
// Shared DPD types: sample typedefs, sequencer state encoding and 20-bit signed limits.
package package_dpd;
    typedef logic signed [19:0] s20;
    typedef logic        [19:0] u20;
    typedef logic        [31:0] u32;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SETTLE,
        SEQ_ADAPT,
        SEQ_GAP,
        SEQ_DONE
    } dpd_seq_state_t;

    localparam s20 S20_MAX = 20'sh7FFFF;
    localparam s20 S20_MIN = 20'sh80000;
endpackage

// File: rtl/dpd_fb_delay.sv
// PA feedback alignment: circular delay line, gain shift and fill tracking.
// Build option DPD_FB_SAT_EN: saturating shift plus saturated-sample counter.
module dpd_fb_delay
    import package_dpd::*;
#(
    parameter int MAX_DELAY = 1024,
    parameter int SHIFT_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset_b,
    input  logic [$clog2(MAX_DELAY)-1:0] fb_delay,
    input  logic [SHIFT_W-1:0]           fb_shift,
    input  logic                         sat_clr,
    input  logic signed [19:0]           fb_in_i,
    input  logic signed [19:0]           fb_in_q,
    output logic signed [19:0]           fb_out_i,
    output logic signed [19:0]           fb_out_q,
    output logic                         fb_valid,
    output logic [15:0]                  sat_cnt
);
    localparam int PTR_W  = $clog2(MAX_DELAY);
    localparam int WIDE_W = 20 + (2 ** SHIFT_W);
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(MAX_DELAY);

    s20               mem_i [MAX_DELAY];
    s20               mem_q [MAX_DELAY];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, dly_q;
    logic [PTR_W:0]   rd_sum, fill, fill_nxt;
    logic             dly_change;
    s20               rd_i_p0, rd_q_p0, sh_i_p0, sh_q_p0;

    function automatic logic signed [19:0] shift_wrap(input logic signed [19:0] x,
                                                      input logic [SHIFT_W-1:0] sh);
        return x <<< sh;
    endfunction

    // Bit 20 of the result flags saturation.
    function automatic logic [20:0] shift_sat(input logic signed [19:0] x,
                                              input logic [SHIFT_W-1:0] sh);
        logic signed [WIDE_W-1:0] wide;
        wide = WIDE_W'(x) <<< sh;
        if (wide > WIDE_W'(S20_MAX)) return {1'b1, S20_MAX};
        else if (wide < WIDE_W'(S20_MIN)) return {1'b1, S20_MIN};
        else return {1'b0, wide[19:0]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, c} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        rd_sum = {1'b0, wr_ptr} - {1'b0, fb_delay};
        if (wr_ptr < fb_delay) rd_sum = rd_sum + DEPTH;
        rd_ptr = rd_sum[PTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        mem_i[wr_ptr] <= fb_in_i;
        mem_q[wr_ptr] <= fb_in_q;
    end

    // p0: read (zero delay bypasses the RAM) and shift
    assign rd_i_p0 = (fb_delay == '0) ? fb_in_i : mem_i[rd_ptr];
    assign rd_q_p0 = (fb_delay == '0) ? fb_in_q : mem_q[rd_ptr];

`ifdef DPD_FB_SAT_EN
    logic [20:0] res_i_p0, res_q_p0;
    assign res_i_p0 = shift_sat(rd_i_p0, fb_shift);
    assign res_q_p0 = shift_sat(rd_q_p0, fb_shift);
    assign sh_i_p0  = res_i_p0[19:0];
    assign sh_q_p0  = res_q_p0[19:0];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)     sat_cnt <= '0;
        else if (sat_clr) sat_cnt <= '0;
        else              sat_cnt <= sat_inc(sat_cnt, {1'b0, res_i_p0[20]} + {1'b0, res_q_p0[20]});
    end
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sh_i_p0 = shift_wrap(rd_i_p0, fb_shift);
    assign sh_q_p0 = shift_wrap(rd_q_p0, fb_shift);
    assign sat_cnt = '0;
`endif

    assign dly_change = (fb_delay != dly_q);
    assign fill_nxt   = dly_change ? '0 : ((fill == DEPTH) ? fill : fill + 1'b1);

    // output register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr   <= '0;
            dly_q    <= '0;
            fill     <= '0;
            fb_valid <= 1'b0;
            fb_out_i <= '0;
            fb_out_q <= '0;
        end else begin
            wr_ptr   <= (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr + 1'b1;
            dly_q    <= fb_delay;
            fill     <= fill_nxt;
            fb_valid <= (fill_nxt > {1'b0, fb_delay});
            fb_out_i <= sh_i_p0;
            fb_out_q <= sh_q_p0;
        end
    end
endmodule

// File: rtl/dpd_adapt_seq.sv
// Adaptation-window sequencer for the dpd core plus the aligned PA feedback path.
// Build option DPD_FB_SAT_EN: saturate the feedback shift and count saturated samples.
module dpd_adapt_seq
    import package_dpd::*;
#(
    parameter int MAX_DELAY = 1024,
    parameter int CNT_W     = 32,
    parameter int SHIFT_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset_b,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         mode_cont,
    input  logic [CNT_W-1:0]             settle_len,
    input  logic [CNT_W-1:0]             adapt_len,
    input  logic [CNT_W-1:0]             gap_len,
    input  logic [$clog2(MAX_DELAY)-1:0] fb_delay,
    input  logic [SHIFT_W-1:0]           fb_shift,
    input  logic signed [19:0]           fb_in_i,
    input  logic signed [19:0]           fb_in_q,
    output logic signed [19:0]           fb_out_i,
    output logic signed [19:0]           fb_out_q,
    output logic                         fb_valid,
    output logic                         dpd_adapt,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sat_cnt
);
    dpd_seq_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] settle_q, adapt_q, gap_q, adapt_last;
    logic             cont_q, launch;

    // A zero-length window still gets one adapt cycle.
    assign adapt_last = (adapt_q == '0) ? '0 : adapt_q - 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        launch    = 1'b0;
        case (state)
            SEQ_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = SEQ_SETTLE;
                    launch    = 1'b1;
                end
            end
            SEQ_SETTLE: if (cnt == settle_q) begin
                state_nxt = SEQ_ADAPT;
                cnt_nxt   = '0;
            end
            SEQ_ADAPT: if (cnt == adapt_last) begin
                cnt_nxt = '0;
                if (!cont_q)          state_nxt = SEQ_DONE;
                else if (gap_q == '0) state_nxt = SEQ_ADAPT;
                else                  state_nxt = SEQ_GAP;
            end
            SEQ_GAP: if (cnt == gap_q - 1'b1) begin
                state_nxt = SEQ_ADAPT;
                cnt_nxt   = '0;
            end
            SEQ_DONE: begin
                state_nxt = SEQ_IDLE;
                cnt_nxt   = '0;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
        if (stop) begin
            state_nxt = SEQ_IDLE;
            cnt_nxt   = '0;
            launch    = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= SEQ_IDLE;
            cnt       <= '0;
            settle_q  <= '0;
            adapt_q   <= '0;
            gap_q     <= '0;
            cont_q    <= 1'b0;
            dpd_adapt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (launch) begin
                settle_q <= settle_len;
                adapt_q  <= adapt_len;
                gap_q    <= gap_len;
                cont_q   <= mode_cont;
            end
            dpd_adapt <= (state_nxt == SEQ_ADAPT);
            busy      <= (state_nxt != SEQ_IDLE);
            done      <= (state_nxt == SEQ_DONE);
        end
    end

    dpd_fb_delay #(
        .MAX_DELAY (MAX_DELAY),
        .SHIFT_W   (SHIFT_W)
    ) u_fb_delay (
        .clk      (clk),
        .reset_b  (reset_b),
        .fb_delay (fb_delay),
        .fb_shift (fb_shift),
        .sat_clr  (launch),
        .fb_in_i  (fb_in_i),
        .fb_in_q  (fb_in_q),
        .fb_out_i (fb_out_i),
        .fb_out_q (fb_out_q),
        .fb_valid (fb_valid),
        .sat_cnt  (sat_cnt)
    );
endmodule

// File: tb/tb_dpd_adapt_seq.sv
// Scoreboard bench for dpd_adapt_seq: window edges and sampled outputs checked against queued expectations.
`timescale 1ns/1ps
module tb_dpd_adapt_seq;
    localparam int MAX_DELAY = 1024;
    localparam int CNT_W     = 32;
    localparam int SHIFT_W   = 3;
    localparam int S_ADAPT = 0, S_BUSY = 1, S_DONE = 2, S_OI = 3, S_OQ = 4, S_VALID = 5, S_SAT = 6;

    logic                         clk = 1'b0;
    logic                         reset_b, start, stop, mode_cont;
    logic [CNT_W-1:0]             settle_len, adapt_len, gap_len;
    logic [$clog2(MAX_DELAY)-1:0] fb_delay;
    logic [SHIFT_W-1:0]           fb_shift;
    logic signed [19:0]           fb_in_i, fb_in_q, fb_out_i, fb_out_q;
    logic                         fb_valid, dpd_adapt, busy, done;
    logic [15:0]                  sat_cnt;

    typedef struct {
        int at;
        int sel;
        int exp;
    } chk_t;

    chk_t pq[$];
    int   rise_q[$], fall_q[$], done_q[$];
    int   cyc = 0, total = 0, passed = 0;
    logic prev_adapt = 1'b0;

    dpd_adapt_seq #(.MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .mode_cont(mode_cont),
        .settle_len(settle_len), .adapt_len(adapt_len), .gap_len(gap_len),
        .fb_delay(fb_delay), .fb_shift(fb_shift), .fb_in_i(fb_in_i), .fb_in_q(fb_in_q),
        .fb_out_i(fb_out_i), .fb_out_q(fb_out_q), .fb_valid(fb_valid),
        .dpd_adapt(dpd_adapt), .busy(busy), .done(done), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sig_val(input int sel);
        case (sel)
            S_ADAPT: return int'(dpd_adapt);
            S_BUSY:  return int'(busy);
            S_DONE:  return int'(done);
            S_OI:    return int'(fb_out_i);
            S_OQ:    return int'(fb_out_q);
            S_VALID: return int'(fb_valid);
            S_SAT:   return int'(sat_cnt);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            S_ADAPT: return "dpd_adapt";
            S_BUSY:  return "busy";
            S_DONE:  return "done";
            S_OI:    return "fb_out_i";
            S_OQ:    return "fb_out_q";
            S_VALID: return "fb_valid";
            S_SAT:   return "sat_cnt";
            default: return "unknown";
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
    endtask

    task automatic expect_at(input int at, input int sel, input int exp);
        chk_t c;
        c.at  = at;
        c.sel = sel;
        c.exp = exp;
        pq.push_back(c);
    endtask

    task automatic take_event(input int kind);
        string nm;
        int    at;
        logic  have;
        have = 1'b0;
        at   = 0;
        nm   = "";
        case (kind)
            0: begin nm = "adapt_rise"; if (rise_q.size() > 0) begin have = 1'b1; at = rise_q.pop_front(); end end
            1: begin nm = "adapt_fall"; if (fall_q.size() > 0) begin have = 1'b1; at = fall_q.pop_front(); end end
            default: begin nm = "done_pulse"; if (done_q.size() > 0) begin have = 1'b1; at = done_q.pop_front(); end end
        endcase
        if (have) check(nm, cyc, at);
        else begin
            total++;
            $display("FAIL %s unexpected at cycle %0d, required none", nm, cyc);
        end
    endtask

    // Monitor: sample on the falling edge, pop expectations as the DUT presents events.
    always @(negedge clk) begin
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].at == cyc) begin
                check(sig_name(pq[i].sel), sig_val(pq[i].sel), pq[i].exp);
                pq.delete(i);
            end
        end
        if (dpd_adapt && !prev_adapt) take_event(0);
        if (!dpd_adapt && prev_adapt) take_event(1);
        if (done) take_event(2);
        prev_adapt = dpd_adapt;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e, n, m, c;
        reset_b = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        settle_len = '0; adapt_len = '0; gap_len = '0;
        fb_delay = '0; fb_shift = '0; fb_in_i = '0; fb_in_q = '0;
        #1 reset_b = 1'b0;
        for (int s = 0; s < 7; s++) expect_at(2, s, 0);
        step(3);
        reset_b = 1'b1;
        step(2);

        // T1 single shot, with mid-sequence input changes and a stray start
        settle_len = 1000; adapt_len = 801; gap_len = 7; mode_cont = 1'b0; start = 1'b1;
        e = cyc + 1;
        rise_q.push_back(e + 1001); fall_q.push_back(e + 1802); done_q.push_back(e + 1802);
        expect_at(e, S_BUSY, 1);
        expect_at(e + 1000, S_ADAPT, 0);
        expect_at(e + 1801, S_ADAPT, 1);
        expect_at(e + 1803, S_BUSY, 0);
        step(1);
        start = 1'b0; settle_len = 5; adapt_len = 5; mode_cont = 1'b1;
        step(499);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1310);

        // T2 continuous, stop mid-window
        settle_len = 0; adapt_len = 4; gap_len = 2; mode_cont = 1'b1; start = 1'b1;
        e = cyc + 1;
        rise_q.push_back(e + 1); rise_q.push_back(e + 7); rise_q.push_back(e + 13);
        fall_q.push_back(e + 5); fall_q.push_back(e + 11); fall_q.push_back(e + 14);
        expect_at(e + 12, S_ADAPT, 0);
        expect_at(e + 13, S_BUSY, 1);
        expect_at(e + 14, S_BUSY, 0);
        step(1);
        start = 1'b0;
        step(13);
        stop = 1'b1;
        step(1);
        stop = 1'b0; mode_cont = 1'b0;
        step(6);

        // T3 delay 500 impulse
        fb_shift = '0; fb_delay = 10'd500;
        n = cyc + 1;
        expect_at(n + 500, S_VALID, 0);
        expect_at(n + 501, S_VALID, 1);
        step(10);
        fb_in_i = 20'sd1000; fb_in_q = -20'sd500;
        m = cyc + 1;
        expect_at(m + 499, S_OI, 0);
        expect_at(m + 500, S_OI, 1000);
        expect_at(m + 500, S_OQ, -500);
        expect_at(m + 501, S_OI, 0);
        step(1);
        fb_in_i = '0; fb_in_q = '0;
        step(520);

        // T4 maximum delay ramp across pointer wrap, then delay change to 3
        fb_delay = 10'(MAX_DELAY - 1);
        n = cyc + 1;
        c = n + 2100;
        expect_at(n + 1023, S_VALID, 0);
        expect_at(n + 1024, S_VALID, 1);
        expect_at(n + 1023, S_OI, n);
        expect_at(n + 1300, S_OI, n + 277);
        expect_at(n + 2000, S_OI, n + 977);
        expect_at(n + 1500, S_OQ, -(n + 477));
        expect_at(c - 1, S_VALID, 1);
        expect_at(c, S_VALID, 0);
        expect_at(c + 3, S_VALID, 0);
        expect_at(c + 4, S_VALID, 1);
        expect_at(c, S_OI, c - 3);
        expect_at(c + 5, S_OI, c + 2);
        for (int k = 0; k < 2110; k++) begin
            fb_in_i = 20'(cyc + 1);
            fb_in_q = -20'(cyc + 1);
            if (cyc + 1 == c) fb_delay = 10'd3;
            step(1);
        end
        fb_in_i = '0; fb_in_q = '0;
        step(2);

        // T5 shift by 3 at zero delay
        fb_delay = '0; fb_shift = 3'd3; fb_in_i = 20'sd100000; fb_in_q = 20'sd1000;
        e = cyc + 1;
`ifdef DPD_FB_SAT_EN
        expect_at(e, S_OI, 524287);
        expect_at(e, S_SAT, 1);
`else
        expect_at(e, S_OI, -248576);
        expect_at(e, S_SAT, 0);
`endif
        expect_at(e, S_OQ, 8000);
        expect_at(e + 1, S_OI, 0);
        step(1);
        fb_in_i = '0; fb_in_q = '0;
        step(3);
        fb_shift = '0;

        // T6a start and stop together
        settle_len = 0; adapt_len = 1; mode_cont = 1'b0; start = 1'b1; stop = 1'b1;
        e = cyc + 1;
        expect_at(e, S_BUSY, 0);
        expect_at(e + 1, S_BUSY, 0);
        expect_at(e + 1, S_ADAPT, 0);
        step(1);
        start = 1'b0; stop = 1'b0;
        step(4);

        // T6b zero adapt length gives a one-cycle window
        settle_len = 2; adapt_len = 0; mode_cont = 1'b0; start = 1'b1;
        e = cyc + 1;
        rise_q.push_back(e + 3); fall_q.push_back(e + 4); done_q.push_back(e + 4);
        expect_at(e, S_SAT, 0);
        step(1);
        start = 1'b0;
        step(8);

        // T6c asynchronous reset while in GAP
        settle_len = 0; adapt_len = 2; gap_len = 5; mode_cont = 1'b1; start = 1'b1; fb_in_i = 20'sd77;
        e = cyc + 1;
        rise_q.push_back(e + 1); fall_q.push_back(e + 3);
        expect_at(e + 3, S_BUSY, 1);
        expect_at(e + 3, S_OI, 77);
        step(1);
        start = 1'b0;
        step(4);
        for (int s = 0; s < 7; s++) expect_at(e + 4, s, 0);
        expect_at(e + 5, S_BUSY, 0);
        expect_at(e + 5, S_VALID, 0);
        reset_b = 1'b0;
        step(2);
        reset_b = 1'b1; fb_in_i = '0; mode_cont = 1'b0;
        step(6);

        foreach (pq[i]) begin
            total++;
            $display("FAIL %s not sampled at cycle %0d, required %0d", sig_name(pq[i].sel), pq[i].at, pq[i].exp);
        end
        foreach (rise_q[i]) begin total++; $display("FAIL adapt_rise missing: got none, required cycle %0d", rise_q[i]); end
        foreach (fall_q[i]) begin total++; $display("FAIL adapt_fall missing: got none, required cycle %0d", fall_q[i]); end
        foreach (done_q[i]) begin total++; $display("FAIL done_pulse missing: got none, required cycle %0d", done_q[i]); end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
